// File: rtl/scoreboard_register_file.sv
// General-purpose register file with two combinational read ports, one write port,
// optional write-to-read bypass and a per-register busy scoreboard for RAW hazard detection.
module scoreboard_register_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              rbusy1,
    output logic              rbusy2,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              flush,
    output logic [ADDR_W:0]   pending_cnt
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [ADDR_W:0]     r_pending_cnt;

    logic [NUM_REGS-1:0] w_busy_nxt;
    logic [ADDR_W:0]     w_cnt_nxt;
    logic                w_wr_ok;
    logic                w_rsv_ok;
    logic                w_zero1;
    logic                w_zero2;
    logic                w_byp1;
    logic                w_byp2;

    // Register 0 absorbs writes and reservations when it is hardwired to zero.
    assign w_wr_ok  = we && !((ZERO_REG != 0) && (waddr == '0));
    assign w_rsv_ok = rsv_en && !flush && !((ZERO_REG != 0) && (rsv_addr == '0));

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_busy_nxt = r_busy;
        if (flush) begin
            w_busy_nxt = '0;
        end else if (w_wr_ok) begin
            w_busy_nxt[waddr] = 1'b0;
        end
        // Reserve is applied last: a newer producer outranks the retiring one.
        if (w_rsv_ok) begin
            w_busy_nxt[rsv_addr] = 1'b1;
        end
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_cnt_nxt = w_cnt_nxt + (ADDR_W + 1)'(w_busy_nxt[i]);
        end
    end

    // NOTE: the data array is reset along with the scoreboard because reads after reset must return zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy        <= '0;
            r_pending_cnt <= '0;
        end else begin
            if (w_wr_ok) begin
                r_regs[waddr] <= wdata;
            end
            r_busy        <= w_busy_nxt;
            r_pending_cnt <= w_cnt_nxt;
        end
    end

    assign w_zero1 = (ZERO_REG != 0) && (raddr1 == '0);
    assign w_zero2 = (ZERO_REG != 0) && (raddr2 == '0);
    assign w_byp1  = (BYPASS != 0) && w_wr_ok && (waddr == raddr1);
    assign w_byp2  = (BYPASS != 0) && w_wr_ok && (waddr == raddr2);

    assign rdata1 = w_zero1 ? '0 : (w_byp1 ? wdata : r_regs[raddr1]);
    assign rdata2 = w_zero2 ? '0 : (w_byp2 ? wdata : r_regs[raddr2]);
    assign rbusy1 = !w_zero1 && !w_byp1 && r_busy[raddr1];
    assign rbusy2 = !w_zero2 && !w_byp2 && r_busy[raddr2];

    assign pending_cnt = r_pending_cnt;

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Bench for scoreboard_register_file: a bypassing and a non-bypassing instance share
// stimulus and are compared against an array-based model of the register/busy rules.
module tb_scoreboard_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  raddr1, raddr2, waddr, rsv_addr;
    logic [31:0] wdata;
    logic        we, rsv_en, flush;

    logic [31:0] rdata1_a, rdata2_a, rdata1_b, rdata2_b;
    logic        rbusy1_a, rbusy2_a, rbusy1_b, rbusy2_b;
    logic [5:0]  cnt_a, cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    always #5 clk = ~clk;

    scoreboard_register_file #(.BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1_a), .rdata2(rdata2_a), .rbusy1(rbusy1_a), .rbusy2(rbusy2_a),
        .we(we), .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .flush(flush), .pending_cnt(cnt_a)
    );

    scoreboard_register_file #(.BYPASS(0)) u_nobyp (
        .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1_b), .rdata2(rdata2_b), .rbusy1(rbusy1_b), .rbusy2(rbusy2_b),
        .we(we), .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .flush(flush), .pending_cnt(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += m_busy[i];
        return c;
    endfunction

    function automatic logic [32:0] model_read(input logic [4:0] a, input bit byp);
        if (a == 0) return 33'd0;
        if (byp && we && waddr == a) return {1'b0, wdata};
        return {m_busy[a], m_regs[a]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (we && waddr != 0) m_regs[waddr] = wdata;
        if (flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else begin
            if (we && waddr != 0) m_busy[waddr] = 1'b0;
            if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
        end
    endtask

    task automatic check_reads();
        logic [32:0] e;
        e = model_read(raddr1, 1'b1);
        check("a.rd1", rdata1_a, e[31:0]); check("a.bz1", 32'(rbusy1_a), 32'(e[32]));
        e = model_read(raddr2, 1'b1);
        check("a.rd2", rdata2_a, e[31:0]); check("a.bz2", 32'(rbusy2_a), 32'(e[32]));
        e = model_read(raddr1, 1'b0);
        check("b.rd1", rdata1_b, e[31:0]); check("b.bz1", 32'(rbusy1_b), 32'(e[32]));
        e = model_read(raddr2, 1'b0);
        check("b.rd2", rdata2_b, e[31:0]); check("b.bz2", 32'(rbusy2_b), 32'(e[32]));
    endtask

    // Inputs are set shortly after a rising edge; reads are checked before the next edge.
    task automatic cycle();
        #1;
        check_reads();
        @(posedge clk);
        model_edge();
        #1;
        check("a.cnt", 32'(cnt_a), 32'(model_count()));
        check("b.cnt", 32'(cnt_b), 32'(model_count()));
    endtask

    task automatic idle();
        we = 1'b0; rsv_en = 1'b0; flush = 1'b0;
        waddr = '0; rsv_addr = '0; wdata = '0;
    endtask

    initial begin
        idle();
        raddr1 = 5'd1; raddr2 = 5'd2;
        rst = 1'b0;
        model_clear();
        #2;
        check("rst.cnt", 32'(cnt_a), 32'd0);
        check("rst.rd1", rdata1_a, 32'd0);
        #10 rst = 1'b1;
        @(posedge clk); #1;

        // Write/read and zero register
        idle(); we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; cycle();
        idle(); we = 1'b1; waddr = 5'd0; wdata = 32'h12345678;
        raddr1 = 5'd5; raddr2 = 5'd0; cycle();
        check("r5", rdata1_a, 32'hDEADBEEF);
        check("r0.data", rdata2_a, 32'd0);
        check("r0.busy", 32'(rbusy2_a), 32'd0);

        // Bypass versus no bypass
        idle(); we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr1 = 5'd7; #1;
        check("byp.data", rdata1_a, 32'hA5A5A5A5);
        check("byp.busy", 32'(rbusy1_a), 32'd0);
        check("nobyp.old", rdata1_b, 32'd0);
        cycle();
        check("nobyp.new", rdata1_b, 32'hA5A5A5A5);

        // Scoreboard
        idle(); rsv_en = 1'b1; rsv_addr = 5'd3; cycle(); check("cnt1", 32'(cnt_a), 32'd1);
        rsv_addr = 5'd4; cycle(); check("cnt2", 32'(cnt_a), 32'd2);
        rsv_addr = 5'd3; cycle(); check("cnt2b", 32'(cnt_a), 32'd2);
        idle(); raddr1 = 5'd3; #1;
        check("r3.busy", 32'(rbusy1_a), 32'd1);
        idle(); we = 1'b1; waddr = 5'd3; wdata = 32'h33; #1;
        check("r3.bypbusy", 32'(rbusy1_a), 32'd0);
        check("r3.nobypbusy", 32'(rbusy1_b), 32'd1);
        cycle(); check("cnt.after_wr", 32'(cnt_a), 32'd1);

        // Simultaneous write and reserve
        idle(); rsv_en = 1'b1; rsv_addr = 5'd9; cycle();
        idle(); we = 1'b1; waddr = 5'd9; wdata = 32'h55; rsv_en = 1'b1; rsv_addr = 5'd9;
        cycle(); check("cnt.same", 32'(cnt_a), 32'd2);
        idle(); raddr1 = 5'd9; #1;
        check("r9.data", rdata1_a, 32'h55);
        check("r9.busy", 32'(rbusy1_a), 32'd1);

        // Flush with reserve and write
        idle(); flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd10;
        we = 1'b1; waddr = 5'd11; wdata = 32'hCAFE; cycle();
        check("flush.cnt", 32'(cnt_a), 32'd0);
        idle(); raddr1 = 5'd11; raddr2 = 5'd10; #1;
        check("r11.data", rdata1_a, 32'hCAFE);
        check("r10.busy", 32'(rbusy2_a), 32'd0);

        // Fill registers then assert reset between edges
        for (int a = 1; a < 32; a++) begin
            idle(); we = 1'b1; waddr = 5'(a); wdata = $urandom() | 32'h1;
            rsv_en = 1'($urandom_range(0, 1)); rsv_addr = 5'($urandom_range(0, 31));
            raddr1 = 5'($urandom_range(0, 31)); raddr2 = 5'($urandom_range(0, 31));
            cycle();
        end
        idle(); rsv_en = 1'b1; rsv_addr = 5'd20; cycle();
        rsv_en = 1'b0; rst = 1'b0;
        model_clear();
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(31 - a); #1;
            check("mrst.rd1", rdata1_a, 32'd0);
            check("mrst.rd2", rdata2_b, 32'd0);
            check("mrst.bz1", 32'(rbusy1_a), 32'd0);
            check("mrst.bz2", 32'(rbusy2_b), 32'd0);
            check("mrst.cnt", 32'(cnt_a), 32'd0);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            we       = 1'($urandom_range(0, 1));
            waddr    = 5'($urandom_range(0, 31));
            wdata    = $urandom();
            rsv_en   = 1'($urandom_range(0, 1));
            rsv_addr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            flush    = ($urandom_range(0, 15) == 0);
            raddr1   = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2   = ($urandom_range(0, 7) == 0) ? raddr1 : 5'($urandom_range(0, 31));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/scoreboard_register_file.md
Name: scoreboard_register_file

Overview:
Parametrised general-purpose register file for the pipelined core, replacing the single-cycle register file. It has two asynchronous read ports, one synchronous write port, and optional write-to-read bypass. A per-register busy scoreboard tracks in-flight producers, so the decode stage can detect RAW hazards and stall.

Parameters:
DATA_W, 32, width of each register and of the data ports
ADDR_W, 5, register address width
NUM_REGS, 32, number of registers; must equal 2**ADDR_W
ZERO_REG, 1, when 1, register 0 is hardwired to zero and can never be busy
BYPASS, 1, when 1, same-cycle write data is forwarded to the read ports

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-low
raddr1  input  ADDR_W  read port 1 address
raddr2  input  ADDR_W  read port 2 address
rdata1  output  DATA_W  read port 1 data, combinational
rdata2  output  DATA_W  read port 2 data, combinational
rbusy1  output  1  register at raddr1 has a pending producer, combinational
rbusy2  output  1  register at raddr2 has a pending producer, combinational
we  input  1  write-back enable
waddr  input  ADDR_W  write-back address
wdata  input  DATA_W  write-back data
rsv_en  input  1  reserve: mark rsv_addr busy (instruction issued)
rsv_addr  input  ADDR_W  reserve address
flush  input  1  clear all busy bits (pipeline flush)
pending_cnt  output  ADDR_W+1  registered count of busy registers

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers are 0, all busy bits are 0, pending_cnt is 0.
  - Reset asserted mid-operation overrides every other input immediately.
- Write:
  - on the clock edge with we=1, regs[waddr] <= wdata and busy[waddr] <= 0.
  - With ZERO_REG=1 and waddr=0 the write is ignored.
- Reserve:
  - on the clock edge with rsv_en=1, busy[rsv_addr] <= 1.
  - With ZERO_REG=1 and rsv_addr=0 the reserve is ignored.
- Simultaneous we and rsv_en to the same address: the data is written and busy ends at 1 (reserve wins; it represents a newer producer).
- Flush:
  - on the clock edge, all busy bits <= 0; the reserve in that cycle is ignored.
  - A write in the same cycle still updates the data.
- Read, with BYPASS=1:
  - if we=1, waddr==raddrN, and (ZERO_REG=0 or waddr!=0): rdataN=wdata and rbusyN=0.
  - otherwise rdataN=regs[raddrN] and rbusyN=busy[raddrN].
- Read, with BYPASS=0: rdataN=regs[raddrN] and rbusyN=busy[raddrN]; a write is visible from the next cycle.
- Register 0 with ZERO_REG=1: rdataN=0 and rbusyN=0 regardless of other inputs.
- Reserving a reservation in the same cycle does not affect rbusy for that cycle; the busy bit is visible from the next cycle.
- pending_cnt:
  - equals the population count of the busy vector after each edge; it is updated in the same edge as the busy bits.
  - Range 0..NUM_REGS (NUM_REGS-1 with ZERO_REG=1).
  - It never wraps.
- Reserving an already-busy register: busy stays 1, count unchanged.
- Writing a non-busy register: busy stays 0, count unchanged.
- Two read ports reading the same address return identical data and busy.

Test Plan:
- Reset:
  - stimulus: write regs 1..31 with nonzero data, then pulse rst low asynchronously between edges.
  - required response: every read returns 0, rbusy=0, pending_cnt=0 immediately.
- Write/read and zero register:
  - stimulus: write 0xDEADBEEF to r5, then 0x12345678 to r0.
  - required response: raddr1=5 returns 0xDEADBEEF the next cycle; raddr2=0 returns 0 and rbusy2=0.
- Bypass:
  - stimulus: BYPASS=1, we=1, waddr=7, wdata=0xA5A5A5A5, raddr1=7 in the same cycle.
  - required response: rdata1=0xA5A5A5A5 combinationally, rbusy1=0.
  - stimulus: same with BYPASS=0.
  - required response: rdata1 shows the old value until after the edge.
- Scoreboard:
  - stimulus: reserve r3, then r4, then r3 again.
  - required response: pending_cnt goes 1, 2, 2; rbusy for r3 is 1.
  - stimulus: write r3.
  - required response: rbusy for r3 is 0 that cycle via bypass; pending_cnt=1 after the edge.
- Simultaneous events:
  - stimulus: r9 busy; same cycle we=1, waddr=9, rsv_en=1, rsv_addr=9, wdata=0x55.
  - required response: after the edge r9=0x55, busy[9]=1, pending_cnt unchanged.
  - stimulus: flush with rsv_en=1, rsv_addr=10, and we=1 to r11.
  - required response: pending_cnt=0, r11 updated, r10 not busy.
